// File: rtl/axi4_bram_slave.sv
// Block-RAM AXI4 responder on a shared read/write address channel, one burst at a time.
// Latency: write beat lands the cycle it is accepted; first rvalid two cycles after the address handshake, then 1 beat per 2 cycles; every channel holds its outputs until the master's ready.
module axi4_bram_slave #(
    parameter int MEM_DEPTH = 4096,
    parameter int ADDR_W    = 12
) (
    input  logic         axi_clk,
    input  logic         axi_reset,
    input  logic [7:0]   axi_aid,
    input  logic [31:0]  axi_aaddr,
    input  logic [7:0]   axi_alen,
    input  logic [2:0]   axi_asize,
    input  logic [1:0]   axi_aburst,
    input  logic [1:0]   axi_alock,
    input  logic         axi_avalid,
    output logic         axi_aready,
    input  logic         axi_atype,
    input  logic [7:0]   axi_wid,
    input  logic [127:0] axi_wdata,
    input  logic [15:0]  axi_wstrb,
    input  logic         axi_wlast,
    input  logic         axi_wvalid,
    output logic         axi_wready,
    output logic [7:0]   axi_bid,
    output logic [1:0]   axi_bresp,
    output logic         axi_bvalid,
    input  logic         axi_bready,
    output logic [7:0]   axi_rid,
    output logic [127:0] axi_rdata,
    output logic [1:0]   axi_rresp,
    output logic         axi_rlast,
    output logic         axi_rvalid,
    input  logic         axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_WRESP  = 3'd2,
        S_RFETCH = 3'd3,
        S_RSEND  = 3'd4
    } state_t;

    state_t state, next_state;

    logic [127:0]      mem [MEM_DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [7:0]        id_q;
    logic [7:0]        len_q;
    logic [7:0]        beat;
    logic              fixed_q;
    logic              err_q;

    logic a_hs, w_hs, r_hs, b_hs;
    logic w_final, err_w;
    logic aready_d, wready_d, bvalid_d, rvalid_d;

    assign a_hs    = axi_avalid & axi_aready;
    assign w_hs    = axi_wvalid & axi_wready;
    assign r_hs    = axi_rvalid & axi_rready;
    assign b_hs    = axi_bvalid & axi_bready;
    assign w_final = (beat == len_q);
    // A wlast on any beat but the counted last one, or a missing final wlast, flags the burst.
    assign err_w   = err_q | (axi_wlast ^ w_final);

    logic unused_ok;
    assign unused_ok = &{1'b0, axi_asize, axi_alock, axi_wid, axi_aaddr[31:ADDR_W+4], axi_aaddr[3:0]};

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) state <= S_IDLE;
        else           state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (a_hs) next_state = axi_atype ? S_WDATA : S_RFETCH;
            S_WDATA:  if (w_hs && w_final) next_state = S_WRESP;
            S_WRESP:  if (b_hs) next_state = S_IDLE;
            S_RFETCH: next_state = S_RSEND;
            S_RSEND:  if (r_hs) next_state = axi_rlast ? S_IDLE : S_RFETCH;
            default:  next_state = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the upcoming state so they track it with no extra cycle.
    always_comb begin
        aready_d = (next_state == S_IDLE);
        wready_d = (next_state == S_WDATA);
        bvalid_d = (next_state == S_WRESP);
        rvalid_d = (next_state == S_RSEND);
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            axi_aready <= 1'b0;
            axi_wready <= 1'b0;
            axi_bvalid <= 1'b0;
            axi_rvalid <= 1'b0;
            axi_bid    <= '0;
            axi_bresp  <= '0;
            axi_rid    <= '0;
            axi_rdata  <= '0;
            axi_rresp  <= '0;
            axi_rlast  <= 1'b0;
            idx        <= '0;
            id_q       <= '0;
            len_q      <= '0;
            beat       <= '0;
            fixed_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            axi_aready <= aready_d;
            axi_wready <= wready_d;
            axi_bvalid <= bvalid_d;
            axi_rvalid <= rvalid_d;
            if (a_hs) begin
                id_q    <= axi_aid;
                idx     <= axi_aaddr[ADDR_W+3:4];
                len_q   <= axi_alen;
                fixed_q <= (axi_aburst == 2'b00);
                err_q   <= axi_aburst[1];
                beat    <= '0;
            end
            if (w_hs) begin
                beat  <= beat + 8'd1;
                err_q <= err_w;
                if (!fixed_q) idx <= idx + ADDR_W'(1);
                if (w_final) begin
                    axi_bid   <= id_q;
                    axi_bresp <= {err_w, 1'b0};
                end
            end
            if (state == S_RFETCH) begin
                axi_rdata <= mem[idx];
                axi_rlast <= (beat == len_q);
                axi_rid   <= id_q;
                axi_rresp <= {err_q, 1'b0};
            end
            if (r_hs) begin
                beat <= beat + 8'd1;
                if (!fixed_q) idx <= idx + ADDR_W'(1);
            end
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge axi_clk) begin
        if (w_hs) begin
            for (int b = 0; b < 16; b++) begin
                if (axi_wstrb[b]) mem[idx][8*b +: 8] <= axi_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi4_bram_slave.sv
// Randomised bench for axi4_bram_slave: a word-array model of the RAM predicts every read beat and response.
module tb_axi4_bram_slave;
    localparam int DEPTH = 4096;

    logic         axi_clk = 1'b0;
    logic         axi_reset;
    logic [7:0]   axi_aid;
    logic [31:0]  axi_aaddr;
    logic [7:0]   axi_alen;
    logic [2:0]   axi_asize;
    logic [1:0]   axi_aburst, axi_alock;
    logic         axi_avalid, axi_aready, axi_atype;
    logic [7:0]   axi_wid;
    logic [127:0] axi_wdata;
    logic [15:0]  axi_wstrb;
    logic         axi_wlast, axi_wvalid, axi_wready;
    logic [7:0]   axi_bid;
    logic [1:0]   axi_bresp;
    logic         axi_bvalid, axi_bready;
    logic [7:0]   axi_rid;
    logic [127:0] axi_rdata;
    logic [1:0]   axi_rresp;
    logic         axi_rlast, axi_rvalid, axi_rready;

    axi4_bram_slave #(.MEM_DEPTH(DEPTH), .ADDR_W(12)) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset),
        .axi_aid(axi_aid), .axi_aaddr(axi_aaddr), .axi_alen(axi_alen), .axi_asize(axi_asize),
        .axi_aburst(axi_aburst), .axi_alock(axi_alock), .axi_avalid(axi_avalid),
        .axi_aready(axi_aready), .axi_atype(axi_atype),
        .axi_wid(axi_wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 axi_clk = ~axi_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] ref_mem [DEPTH];
    logic [127:0] wbuf  [256];
    logic [15:0]  sbuf  [256];
    logic         lbuf  [256];
    logic [127:0] rbuf  [256];
    logic         rlbuf [256];
    logic [7:0]   ridbuf[256];
    logic [1:0]   rrbuf [256];

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [152:0] outs();
        return {axi_aready, axi_wready, axi_bvalid, axi_rvalid, axi_bid, axi_bresp,
                axi_rid, axi_rdata, axi_rresp, axi_rlast};
    endfunction

    // Word touched by beat b: FIXED stays put, INCR/WRAP step by one modulo the memory depth.
    function automatic int word_of(input logic [31:0] addr, input logic [1:0] burst, input int b);
        int w;
        w = int'(addr[15:4]);
        if (burst != 2'b00) w = (w + b) % DEPTH;
        return w;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input int len, input logic [1:0] burst);
        for (int b = 0; b <= len; b++) begin
            int w;
            w = word_of(addr, burst, b);
            for (int k = 0; k < 16; k++)
                if (sbuf[b][k]) ref_mem[w][8*k +: 8] = wbuf[b][8*k +: 8];
        end
    endfunction

    function automatic logic [1:0] exp_wresp(input int len, input logic [1:0] burst);
        logic err;
        err = burst[1];
        for (int b = 0; b <= len; b++)
            if (lbuf[b] !== (b == len)) err = 1'b1;
        return {err, 1'b0};
    endfunction

    task automatic drive_addr(input logic [7:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst, input logic wr, output bit ok);
        axi_aid = id; axi_aaddr = addr; axi_alen = len[7:0]; axi_aburst = burst;
        axi_atype = wr; axi_asize = 3'd4; axi_alock = 2'd0; axi_avalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = axi_aready;
            @(posedge axi_clk); #1;
        end
        axi_avalid = 1'b0;
    endtask

    task automatic drive_wdata(input bit gaps, output int beats);
        int b;
        bit hs;
        b = 0;
        for (int c = 0; c < 2000; c++) begin
            if (b > 0 && !axi_wready) break;
            axi_wvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            axi_wdata  = wbuf[b % 256];
            axi_wstrb  = sbuf[b % 256];
            axi_wlast  = lbuf[b % 256];
            axi_wid    = 8'h00;
            hs = axi_wvalid && axi_wready;
            @(posedge axi_clk); #1;
            if (hs) b++;
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        beats = b;
    endtask

    task automatic get_bresp(input int delay, output logic [7:0] id, output logic [1:0] resp,
                             output int vcycles, output bit stable, output bit ok);
        stable = 1'b1; vcycles = 0; ok = 1'b0; id = '0; resp = '0;
        for (int c = 0; c < 50 && !axi_bvalid; c++) begin
            @(posedge axi_clk); #1;
        end
        if (!axi_bvalid) begin
            axi_bready = 1'b0;
            return;
        end
        id = axi_bid; resp = axi_bresp;
        for (int c = 0; c < 100; c++) begin
            if (!axi_bvalid) break;
            if (axi_bid !== id || axi_bresp !== resp) stable = 1'b0;
            vcycles++;
            if (vcycles > delay) axi_bready = 1'b1;
            @(posedge axi_clk); #1;
        end
        axi_bready = 1'b0;
        ok = 1'b1;
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input bit gaps, input int bdelay, input bit pre,
                            output int beats, output logic [7:0] bid, output logic [1:0] bresp,
                            output int bcycles, output bit bstable, output bit ok);
        bit aok;
        axi_bready = pre;
        drive_addr(id, addr, len, burst, 1'b1, aok);
        drive_wdata(gaps, beats);
        get_bresp(bdelay, bid, bresp, bcycles, bstable, ok);
        ok = ok && aok;
    endtask

    // mode 0: rready always high, 1: toggled every cycle, 2: random
    task automatic read_beats(input int mode, output int n, output bit stable, output int lat);
        logic [127:0] pd;
        logic pl;
        logic [1:0] pr;
        logic [7:0] pi;
        bit pstall, hs, last, tog;
        n = 0; stable = 1'b1; lat = 0; pstall = 1'b0; tog = 1'b0;
        pd = '0; pl = 1'b0; pr = '0; pi = '0;
        for (int c = 0; c < 50 && !axi_rvalid; c++) begin
            lat++;
            @(posedge axi_clk); #1;
        end
        for (int c = 0; c < 3000; c++) begin
            case (mode)
                0:       axi_rready = 1'b1;
                1:       begin axi_rready = tog; tog = !tog; end
                default: axi_rready = 1'($urandom_range(0, 1));
            endcase
            if (pstall && (!axi_rvalid || axi_rdata !== pd || axi_rlast !== pl ||
                           axi_rresp !== pr || axi_rid !== pi)) stable = 1'b0;
            hs = axi_rvalid && axi_rready;
            last = axi_rlast;
            if (hs && n < 256) begin
                rbuf[n] = axi_rdata; rlbuf[n] = axi_rlast; ridbuf[n] = axi_rid; rrbuf[n] = axi_rresp;
            end
            pstall = axi_rvalid && !axi_rready;
            pd = axi_rdata; pl = axi_rlast; pr = axi_rresp; pi = axi_rid;
            @(posedge axi_clk); #1;
            if (hs) n++;
            if (hs && last) break;
        end
        axi_rready = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int mode,
                           output int n, output bit stable, output int lat, output bit ok);
        drive_addr(id, addr, len, burst, 1'b0, ok);
        read_beats(mode, n, stable, lat);
    endtask

    task automatic test_reset();
        axi_reset = 1'b0; axi_avalid = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0; axi_rready = 1'b0;
        axi_aid = '0; axi_aaddr = '0; axi_alen = '0; axi_asize = '0; axi_aburst = '0; axi_alock = '0;
        axi_atype = 1'b0; axi_wid = '0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0;
        #1 axi_reset = 1'b1;
        #11;
        n_checks++;
        if (outs() !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h, want 0", outs()); end
        @(negedge axi_clk); axi_reset = 1'b0; #1;
        n_checks++;
        if (axi_aready !== 1'b0) begin n_fail++; $display("FAIL reset_aready_release: got %b, want 0", axi_aready); end
        @(posedge axi_clk); #1;
        n_checks++;
        if (outs() !== {1'b1, 152'd0}) begin n_fail++; $display("FAIL reset_first_clock: got %h, want aready only", outs()); end
    endtask

    task automatic test_incr();
        logic [7:0] id, bid; logic [1:0] bresp; int beats, bc, n, lat; bit bst, ok, st;
        id = 8'($urandom);
        for (int b = 0; b < 64; b++) begin wbuf[b] = 128'(b); sbuf[b] = 16'hFFFF; lbuf[b] = (b == 63); end
        do_write(id, 32'h0, 63, 2'b01, 1'b0, 0, 1'b0, beats, bid, bresp, bc, bst, ok);
        model_write(32'h0, 63, 2'b01);
        n_checks++;
        if (!ok || beats !== 64) begin n_fail++; $display("FAIL incr_wbeats: got %0d ok=%0d, want 64 ok=1", beats, ok); end
        n_checks++;
        if (bid !== id || bresp !== 2'b00) begin n_fail++; $display("FAIL incr_bresp: got id=%h resp=%b, want id=%h resp=00", bid, bresp, id); end
        id = id + 8'd7;
        do_read(id, 32'h0, 63, 2'b01, 0, n, st, lat, ok);
        n_checks++;
        if (!ok || n !== 64) begin n_fail++; $display("FAIL incr_rbeats: got %0d ok=%0d, want 64", n, ok); end
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL incr_first_rvalid: got %0d idle samples, want 1", lat); end
        for (int b = 0; b < n && b < 256; b++) begin
            n_checks++;
            if (rbuf[b] !== 128'(b) || rlbuf[b] !== (b == 63) || ridbuf[b] !== id || rrbuf[b] !== 2'b00) begin
                n_fail++;
                $display("FAIL incr_rbeat%0d: data=%h last=%b id=%h resp=%b, want data=%h last=%b id=%h resp=00",
                         b, rbuf[b], rlbuf[b], ridbuf[b], rrbuf[b], 128'(b), (b == 63), id);
            end
        end
    endtask

    task automatic test_strobe();
        logic [7:0] bid; logic [1:0] bresp; int beats, bc, n, lat, w; bit bst, ok, st;
        logic [31:0] addr;
        w = $urandom_range(2000, 3000);
        addr = 32'(w) << 4;
        wbuf[0] = '0; sbuf[0] = 16'hFFFF; lbuf[0] = 1'b1;
        do_write(8'h11, addr, 0, 2'b01, 1'b0, 0, 1'b0, beats, bid, bresp, bc, bst, ok);
        model_write(addr, 0, 2'b01);
        wbuf[0] = '1; sbuf[0] = 16'h000F;
        do_write(8'h12, addr, 0, 2'b01, 1'b0, 0, 1'b0, beats, bid, bresp, bc, bst, ok);
        model_write(addr, 0, 2'b01);
        n_checks++;
        if (!ok || beats !== 1 || bresp !== 2'b00) begin n_fail++; $display("FAIL strobe_write: beats=%0d resp=%b ok=%0d, want 1 00 1", beats, bresp, ok); end
        do_read(8'h13, addr, 0, 2'b01, 0, n, st, lat, ok);
        n_checks++;
        if (!ok || n !== 1 || rbuf[0] !== 128'hFFFF_FFFF || rbuf[0] !== ref_mem[w] || rlbuf[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL strobe_read: n=%0d data=%h last=%b, want n=1 data=%h last=1", n, rbuf[0], rlbuf[0], 128'hFFFF_FFFF);
        end
    endtask

    task automatic test_mem_wrap();
        logic [7:0] bid; logic [1:0] bresp; int beats, bc, n, lat; bit bst, ok, st;
        logic [31:0] addr;
        addr = 32'(DEPTH - 2) << 4;
        for (int b = 0; b < 4; b++) begin wbuf[b] = rand128(); sbuf[b] = 16'hFFFF; lbuf[b] = (b == 3); end
        do_write(8'h21, addr, 3, 2'b01, 1'b1, 0, 1'b0, beats, bid, bresp, bc, bst, ok);
        model_write(addr, 3, 2'b01);
        n_checks++;
        if (!ok || beats !== 4 || bresp !== 2'b00) begin n_fail++; $display("FAIL wrap_write: beats=%0d resp=%b, want 4 00", beats, bresp); end
        // High address bits are outside the RAM and must not move the word index.
        do_read(8'h22, 32'h5A5A_0000, 1, 2'b01, 0, n, st, lat, ok);
        n_checks++;
        if (!ok || n !== 2 || rbuf[0] !== wbuf[2] || rbuf[1] !== wbuf[3]) begin
            n_fail++;
            $display("FAIL wrap_word0: n=%0d got %h %h, want %h %h", n, rbuf[0], rbuf[1], wbuf[2], wbuf[3]);
        end
        do_read(8'h23, addr, 3, 2'b01, 2, n, st, lat, ok);
        n_checks++;
        if (!ok || n !== 4 || rbuf[0] !== wbuf[0] || rbuf[1] !== wbuf[1] || rbuf[2] !== wbuf[2] || rbuf[3] !== wbuf[3]) begin
            n_fail++;
            $display("FAIL wrap_readback: n=%0d got beat0=%h beat3=%h, want %h %h", n, rbuf[0], rbuf[3], wbuf[0], wbuf[3]);
        end
    endtask

    task automatic test_random();
        logic [7:0] id, bid; logic [1:0] bresp, burst, er; int beats, bc, n, lat, len, w, bdelay; bit bst, ok, st;
        logic [31:0] addr;
        for (int b = 0; b < 256; b++) begin wbuf[b] = rand128(); sbuf[b] = 16'hFFFF; lbuf[b] = (b == 255); end
        do_write(8'h30, 32'(1024) << 4, 255, 2'b01, 1'b0, 0, 1'b1, beats, bid, bresp, bc, bst, ok);
        model_write(32'(1024) << 4, 255, 2'b01);
        n_checks++;
        if (!ok || beats !== 256 || bresp !== 2'b00) begin n_fail++; $display("FAIL rand_fill: beats=%0d resp=%b, want 256 00", beats, bresp); end
        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(0, 15);
            burst = 2'($urandom_range(0, 3));
            w = $urandom_range(1024, 1264);
            addr = ($urandom & 32'hFFFF_000F) | (32'(w) << 4);
            id = 8'($urandom);
            bdelay = $urandom_range(0, 3);
            for (int b = 0; b <= len; b++) begin wbuf[b] = rand128(); sbuf[b] = 16'($urandom); lbuf[b] = (b == len); end
            do_write(id, addr, len, burst, 1'b1, bdelay, 1'b0, beats, bid, bresp, bc, bst, ok);
            model_write(addr, len, burst);
            er = exp_wresp(len, burst);
            n_checks++;
            if (!ok || beats !== len + 1 || bid !== id || bresp !== er || bc !== bdelay + 1 || !bst) begin
                n_fail++;
                $display("FAIL rand_write%0d: beats=%0d id=%h resp=%b bcyc=%0d, want %0d %h %b %0d", it, beats, bid, bresp, bc, len + 1, id, er, bdelay + 1);
            end
            id = id ^ 8'h55;
            do_read(id, addr, len, burst, 2, n, st, lat, ok);
            n_checks++;
            if (!ok || n !== len + 1 || !st) begin n_fail++; $display("FAIL rand_read%0d: n=%0d stable=%0d, want %0d 1", it, n, st, len + 1); end
            for (int b = 0; b < n && b < 256; b++) begin
                n_checks++;
                if (rbuf[b] !== ref_mem[word_of(addr, burst, b)] || rlbuf[b] !== (b == len) || ridbuf[b] !== id || rrbuf[b] !== {burst[1], 1'b0}) begin
                    n_fail++;
                    $display("FAIL rand_rbeat%0d_%0d: data=%h last=%b id=%h resp=%b, want data=%h last=%b id=%h resp=%b",
                             it, b, rbuf[b], rlbuf[b], ridbuf[b], rrbuf[b], ref_mem[word_of(addr, burst, b)], (b == len), id, {burst[1], 1'b0});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] bid; logic [1:0] bresp; int beats, bc, n, lat; bit bst, ok, st;
        logic [31:0] addr;
        addr = 32'(300) << 4;
        for (int b = 0; b < 8; b++) begin wbuf[b] = rand128(); sbuf[b] = 16'hFFFF; lbuf[b] = (b == 7); end
        do_write(8'h41, addr, 7, 2'b01, 1'b1, 5, 1'b0, beats, bid, bresp, bc, bst, ok);
        model_write(addr, 7, 2'b01);
        n_checks++;
        if (!ok || bc !== 6 || !bst || bid !== 8'h41) begin n_fail++; $display("FAIL bp_bready_low: bvalid cycles=%0d stable=%0d id=%h, want 6 1 41", bc, bst, bid); end
        for (int m = 1; m <= 2; m++) begin
            do_read(8'h42, addr, 7, 2'b01, m, n, st, lat, ok);
            n_checks++;
            if (!ok || n !== 8 || !st) begin n_fail++; $display("FAIL bp_read_mode%0d: n=%0d stable=%0d, want 8 1", m, n, st); end
            for (int b = 0; b < n && b < 256; b++) begin
                n_checks++;
                if (rbuf[b] !== ref_mem[300 + b] || rlbuf[b] !== (b == 7)) begin
                    n_fail++;
                    $display("FAIL bp_rbeat%0d_%0d: data=%h last=%b, want %h %b", m, b, rbuf[b], rlbuf[b], ref_mem[300 + b], (b == 7));
                end
            end
        end
        do_write(8'h43, addr, 7, 2'b01, 1'b0, 0, 1'b1, beats, bid, bresp, bc, bst, ok);
        model_write(addr, 7, 2'b01);
        n_checks++;
        if (!ok || bc !== 1 || bresp !== 2'b00) begin n_fail++; $display("FAIL bp_bready_pre: bvalid cycles=%0d resp=%b, want 1 00", bc, bresp); end
    endtask

    task automatic test_errors();
        logic [7:0] bid; logic [1:0] bresp; int beats, bc, n, lat; bit bst, ok, st;
        logic [31:0] addr;
        addr = 32'(400) << 4;
        for (int b = 0; b < 8; b++) begin wbuf[b] = rand128(); sbuf[b] = 16'hFFFF; lbuf[b] = (b == 2); end
        do_write(8'h51, addr, 7, 2'b01, 1'b0, 0, 1'b0, beats, bid, bresp, bc, bst, ok);
        model_write(addr, 7, 2'b01);
        n_checks++;
        if (!ok || beats !== 8 || bresp !== 2'b10) begin n_fail++; $display("FAIL err_early_wlast: beats=%0d resp=%b, want 8 10", beats, bresp); end
        do_read(8'h52, addr, 7, 2'b10, 1, n, st, lat, ok);
        n_checks++;
        if (!ok || n !== 8) begin n_fail++; $display("FAIL err_wrap_read: n=%0d, want 8", n); end
        for (int b = 0; b < n && b < 256; b++) begin
            n_checks++;
            if (rbuf[b] !== wbuf[b] || rrbuf[b] !== 2'b10 || rlbuf[b] !== (b == 7)) begin
                n_fail++;
                $display("FAIL err_rbeat%0d: data=%h resp=%b last=%b, want %h 10 %b", b, rbuf[b], rrbuf[b], rlbuf[b], wbuf[b], (b == 7));
            end
        end
        wbuf[0] = rand128(); sbuf[0] = 16'hFFFF; lbuf[0] = 1'b0;
        do_write(8'h53, addr, 0, 2'b00, 1'b0, 0, 1'b0, beats, bid, bresp, bc, bst, ok);
        model_write(addr, 0, 2'b00);
        n_checks++;
        if (!ok || beats !== 1 || bresp !== 2'b10) begin n_fail++; $display("FAIL err_missing_wlast: beats=%0d resp=%b, want 1 10", beats, bresp); end
        lbuf[0] = 1'b1;
        do_write(8'h54, addr, 0, 2'b00, 1'b0, 0, 1'b0, beats, bid, bresp, bc, bst, ok);
        n_checks++;
        if (!ok || bresp !== 2'b00) begin n_fail++; $display("FAIL err_clean_after: resp=%b, want 00", bresp); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bid; logic [1:0] bresp; int beats, bc, n, lat, cnt; bit bst, ok, st, hs;
        logic [31:0] addr;
        addr = 32'(512) << 4;
        for (int b = 0; b < 64; b++) begin wbuf[b] = rand128(); sbuf[b] = 16'hFFFF; lbuf[b] = (b == 63); end
        do_write(8'h61, addr, 63, 2'b01, 1'b0, 0, 1'b1, beats, bid, bresp, bc, bst, ok);
        model_write(addr, 63, 2'b01);
        drive_addr(8'h62, addr, 63, 2'b01, 1'b0, ok);
        axi_rready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 200 && cnt < 5; c++) begin
            hs = axi_rvalid && axi_rready;
            @(posedge axi_clk); #1;
            if (hs) cnt++;
        end
        #2 axi_reset = 1'b1;
        #1;
        n_checks++;
        if (!ok || cnt !== 5 || outs() !== '0) begin n_fail++; $display("FAIL rstmid_outputs: beats=%0d outs=%h, want 5 and 0", cnt, outs()); end
        axi_rready = 1'b0;
        @(negedge axi_clk); @(negedge axi_clk);
        axi_reset = 1'b0; #1;
        n_checks++;
        if (axi_aready !== 1'b0) begin n_fail++; $display("FAIL rstmid_release: aready=%b, want 0", axi_aready); end
        @(posedge axi_clk); #1;
        n_checks++;
        if (axi_aready !== 1'b1 || axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_aready: aready=%b rvalid=%b, want 1 0", axi_aready, axi_rvalid); end
        do_read(8'h63, addr, 63, 2'b01, 2, n, st, lat, ok);
        n_checks++;
        if (!ok || n !== 64 || !st) begin n_fail++; $display("FAIL rstmid_reread: n=%0d stable=%0d, want 64 1", n, st); end
        for (int b = 0; b < n && b < 256; b++) begin
            n_checks++;
            if (rbuf[b] !== ref_mem[512 + b] || rlbuf[b] !== (b == 63) || ridbuf[b] !== 8'h63) begin
                n_fail++;
                $display("FAIL rstmid_rbeat%0d: data=%h last=%b id=%h, want %h %b 63", b, rbuf[b], rlbuf[b], ridbuf[b], ref_mem[512 + b], (b == 63));
            end
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_strobe();
        test_mem_wrap();
        test_random();
        test_backpressure();
        test_errors();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
